// File: rtl/alu_seq_unit_if.sv
// ALU sequencer bus: operands, opcode, start/flag-write controls
// and registered result, flags, Busy and Done back to the datapath.
interface alu_seq_unit_if;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  FunSel;
   logic        Start;
   logic        WF;
   logic [15:0] ALUOut;
   logic [3:0]  FlagsOut;
   logic        Busy;
   logic        Done;

   modport master (
      output A, B, FunSel, Start, WF,
      input  ALUOut, FlagsOut, Busy, Done
   );

   modport slave (
      input  A, B, FunSel, Start, WF,
      output ALUOut, FlagsOut, Busy, Done
   );
endinterface

// File: rtl/alu_seq_unit.sv
// 16-bit ALU, single-cycle ops plus 16-cycle shift-add multiply.
// Ports: Clock, Reset (async high), bus (slave: A,B,FunSel,Start,WF -> ALUOut,FlagsOut{Z,C,N,O},Busy,Done).
module alu_seq_unit (
   input logic         Clock,
   input logic         Reset,
   alu_seq_unit_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] F_MUL = 4'b1111;

   state_t      state, state_n;
   logic [31:0] mcand;
   logic [15:0] mplr;
   logic [31:0] prod;
   logic [31:0] prod_n;
   logic [3:0]  cnt;
   logic        wf_q;

   logic [15:0] res;
   logic [16:0] sum;
   logic        c_n, o_n;
   logic        c_in, o_in;

   assign c_in = bus.FlagsOut[2];
   assign o_in = bus.FlagsOut[0];

   // Single-cycle datapath works straight off the live inputs,
   // which are what gets latched on the Start edge.
   always_comb begin
      res = 16'h0000;
      sum = 17'h0;
      c_n = c_in;
      o_n = o_in;
      unique case (bus.FunSel)
         4'b0000: res = bus.A;
         4'b0001: res = bus.B;
         4'b0010: res = ~bus.A;
         4'b0011: res = ~bus.B;
         4'b0100, 4'b0101: begin
            sum = {1'b0, bus.A} + {1'b0, bus.B}
                + {16'h0, (bus.FunSel[0] & c_in)};
            res = sum[15:0];
            c_n = sum[16];
            o_n = (bus.A[15] == bus.B[15]) && (res[15] != bus.A[15]);
         end
         4'b0110: begin
            res = bus.A - bus.B;
            c_n = bus.A < bus.B;
            o_n = (bus.A[15] != bus.B[15]) && (res[15] != bus.A[15]);
         end
         4'b0111: res = bus.A & bus.B;
         4'b1000: res = bus.A | bus.B;
         4'b1001: res = bus.A ^ bus.B;
         4'b1010: begin
            res = {bus.A[14:0], 1'b0};
            c_n = bus.A[15];
         end
         4'b1011: begin
            res = {1'b0, bus.A[15:1]};
            c_n = bus.A[0];
         end
         4'b1100: begin
            res = {bus.A[15], bus.A[15:1]};
            c_n = bus.A[0];
            o_n = 1'b0;
         end
         4'b1101: begin
            res = {bus.A[14:0], c_in};
            c_n = bus.A[15];
         end
         4'b1110: begin
            res = {c_in, bus.A[15:1]};
            c_n = bus.A[0];
         end
         default: res = 16'h0000;
      endcase
   end

   assign prod_n = prod + (mplr[0] ? mcand : 32'h0);

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: if (bus.Start)
            state_n = (bus.FunSel == F_MUL) ? S_MUL : S_DONE;
         S_MUL:  if (cnt == 4'd15) state_n = S_DONE;
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.Busy = (state == S_MUL);
   assign bus.Done = (state == S_DONE);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= S_IDLE;
         mcand        <= 32'h0;
         mplr         <= 16'h0;
         prod         <= 32'h0;
         cnt          <= 4'd0;
         wf_q         <= 1'b0;
         bus.ALUOut   <= 16'h0000;
         bus.FlagsOut <= 4'b0000;
      end else begin
         state <= state_n;
         unique case (state)
            S_IDLE: if (bus.Start) begin
               wf_q <= bus.WF;
               if (bus.FunSel == F_MUL) begin
                  mcand <= {16'h0, bus.A};
                  mplr  <= bus.B;
                  prod  <= 32'h0;
                  cnt   <= 4'd0;
               end else begin
                  bus.ALUOut <= res;
                  if (bus.WF)
                     bus.FlagsOut <= {res == 16'h0, c_n, res[15], o_n};
               end
            end
            S_MUL: begin
               prod  <= prod_n;
               mcand <= {mcand[30:0], 1'b0};
               mplr  <= {1'b0, mplr[15:1]};
               cnt   <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  bus.ALUOut <= prod_n[15:0];
                  if (wf_q)
                     bus.FlagsOut <= {prod_n[15:0] == 16'h0,
                                      prod_n[31:16] != 16'h0,
                                      prod_n[15], o_in};
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: single-cycle ops, flags,
// multiply timing, ignored starts and mid-multiply reset.
module tb_alu_seq_unit;
   logic Clock;
   logic Reset;
   int   passed;
   int   total;

   alu_seq_unit_if bus ();

   alu_seq_unit dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clock = ~Clock;

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, input logic wf);
      @(negedge Clock);
      bus.A = a; bus.B = b; bus.FunSel = f; bus.WF = wf; bus.Start = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      total++;
      if ({bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut} !== 22'h0)
         $display("FAIL reset_state got %h want 0",
                  {bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut});
      else passed++;
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      total++;
      if ({bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut} !== 22'h0)
         $display("FAIL reset_release got %h want 0",
                  {bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut});
      else passed++;
   endtask

   task automatic test_add;
      do_op(16'h7FFF, 16'h0001, 4'b0100, 1'b1);
      total++;
      if ({bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut}
          !== {1'b1, 1'b0, 16'h8000, 4'b0011})
         $display("FAIL add_ovf got %h/%h D%b B%b want 8000/3 D1 B0",
                  bus.ALUOut, bus.FlagsOut, bus.Done, bus.Busy);
      else passed++;
      @(negedge Clock);
      total++;
      if ({bus.Done, bus.ALUOut} !== {1'b0, 16'h8000})
         $display("FAIL done_pulse got D%b %h want D0 8000",
                  bus.Done, bus.ALUOut);
      else passed++;
      do_op(16'hFFFF, 16'h0001, 4'b0100, 1'b1);
      total++;
      if ({bus.ALUOut, bus.FlagsOut} !== {16'h0000, 4'b1100})
         $display("FAIL add_carry got %h/%h want 0000/c",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
      do_op(16'h0001, 16'h0001, 4'b0101, 1'b1);
      total++;
      if ({bus.ALUOut, bus.FlagsOut} !== {16'h0003, 4'b0000})
         $display("FAIL adc got %h/%h want 0003/0",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
   endtask

   task automatic test_sub;
      do_op(16'h0003, 16'h0005, 4'b0110, 1'b1);
      total++;
      if ({bus.Done, bus.ALUOut, bus.FlagsOut} !== {1'b1, 16'hFFFE, 4'b0110})
         $display("FAIL sub_borrow got %h/%h want fffe/6",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
      do_op(16'h0005, 16'h0005, 4'b0110, 1'b0);
      total++;
      if ({bus.ALUOut, bus.FlagsOut} !== {16'h0000, 4'b0110})
         $display("FAIL sub_nowf got %h/%h want 0000/6",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
   endtask

   task automatic test_rotate;
      do_op(16'h8001, 16'h0000, 4'b1101, 1'b1);
      total++;
      if ({bus.ALUOut, bus.FlagsOut} !== {16'h0003, 4'b0100})
         $display("FAIL csl got %h/%h want 0003/4",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
      do_op(16'h0002, 16'h0000, 4'b1110, 1'b1);
      total++;
      if ({bus.ALUOut, bus.FlagsOut} !== {16'h8001, 4'b0010})
         $display("FAIL csr got %h/%h want 8001/2",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
   endtask

   task automatic test_logic;
      do_op(16'hFFFF, 16'hFFFF, 4'b1001, 1'b1);
      total++;
      if ({bus.ALUOut, bus.FlagsOut} !== {16'h0000, 4'b1000})
         $display("FAIL xor got %h/%h want 0000/8",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
      do_op(16'h0000, 16'h1234, 4'b0010, 1'b1);
      total++;
      if ({bus.ALUOut, bus.FlagsOut} !== {16'hFFFF, 4'b0010})
         $display("FAIL not_a got %h/%h want ffff/2",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
      do_op(16'h8003, 16'h0000, 4'b1100, 1'b1);
      total++;
      if ({bus.ALUOut, bus.FlagsOut} !== {16'hC001, 4'b0110})
         $display("FAIL asr got %h/%h want c001/6",
                  bus.ALUOut, bus.FlagsOut);
      else passed++;
   endtask

   task automatic test_mul;
      int busy_cnt;
      int waited;
      busy_cnt = 0;
      do_op(16'h0100, 16'h0100, 4'b1111, 1'b1);
      for (int k = 1; k <= 16; k++) begin
         if (bus.Busy === 1'b1 && bus.Done === 1'b0) busy_cnt++;
         if (k == 3 || k == 10) begin
            bus.A = 16'h1234; bus.B = 16'h0007;
            bus.FunSel = 4'b0000; bus.Start = 1'b1;
         end else bus.Start = 1'b0;
         @(negedge Clock);
      end
      bus.Start = 1'b0;
      total++;
      if (busy_cnt !== 16)
         $display("FAIL mul_busy got %0d cycles want 16", busy_cnt);
      else passed++;
      total++;
      if ({bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut}
          !== {1'b1, 1'b0, 16'h0000, 4'b1100})
         $display("FAIL mul_done got D%b B%b %h/%h want D1 B0 0000/c",
                  bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut);
      else passed++;
      bus.Start = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
      total++;
      if ({bus.Done, bus.Busy, bus.ALUOut} !== {1'b0, 1'b0, 16'h0000})
         $display("FAIL start_in_done got D%b B%b %h want D0 B0 0000",
                  bus.Done, bus.Busy, bus.ALUOut);
      else passed++;
      do_op(16'h0123, 16'h0045, 4'b1111, 1'b1);
      waited = 0;
      while (bus.Done !== 1'b1 && waited < 40) begin
         @(negedge Clock);
         waited++;
      end
      total++;
      if (waited !== 16 || {bus.ALUOut, bus.FlagsOut} !== {16'h4E6F, 4'b0000})
         $display("FAIL mul2 got %h/%h after %0d want 4e6f/0 after 16",
                  bus.ALUOut, bus.FlagsOut, waited);
      else passed++;
   endtask

   task automatic test_reset_mid_mul;
      int dones;
      dones = 0;
      do_op(16'h0000, 16'h0000, 4'b0011, 1'b1);
      do_op(16'h0100, 16'h0100, 4'b1111, 1'b1);
      repeat (6) @(negedge Clock);
      @(posedge Clock);
      #2 Reset = 1'b1;
      #1;
      total++;
      if ({bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut} !== 22'h0)
         $display("FAIL reset_async got %h want 0",
                  {bus.Done, bus.Busy, bus.ALUOut, bus.FlagsOut});
      else passed++;
      for (int k = 0; k < 20; k++) begin
         @(negedge Clock);
         if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) dones++;
         if (k == 2) Reset = 1'b0;
      end
      total++;
      if (dones !== 0 || bus.ALUOut !== 16'h0000)
         $display("FAIL reset_abort got %0d active cycles %h want 0 0000",
                  dones, bus.ALUOut);
      else passed++;
      bus.A = 16'h1234; bus.B = 16'h0000;
      bus.FunSel = 4'b0000; bus.WF = 1'b1; bus.Start = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
      total++;
      if ({bus.Done, bus.ALUOut, bus.FlagsOut} !== {1'b1, 16'h1234, 4'b0000})
         $display("FAIL post_reset got D%b %h/%h want D1 1234/0",
                  bus.Done, bus.ALUOut, bus.FlagsOut);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total = 0;
      Clock = 1'b0;
      Reset = 1'b1;
      bus.A = 16'h0; bus.B = 16'h0; bus.FunSel = 4'h0;
      bus.Start = 1'b0; bus.WF = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_rotate();
      test_logic();
      test_mul();
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named Clock and Reset.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous active-high clear of all state and outputs.
REQ-004 A  input  16  operand A, driven from register-file OutA.
REQ-005 B  input  16  operand B, driven from register-file OutB.
REQ-006 FunSel  input  4  operation code, decoded per REQ-013.
REQ-007 Start  input  1  request to begin an operation; sampled only when Busy=0.
REQ-008 WF  input  1  flag write enable; sampled together with Start.
REQ-009 ALUOut  output  16  registered result, fed back to register-file input I.
REQ-010 FlagsOut  output  4  registered flags {Z,C,N,O}, MSB first.
REQ-011 Busy  output  1  high while a multi-cycle operation runs.
REQ-012 Done  output  1  one-cycle pulse marking that ALUOut/FlagsOut are valid.

Function
REQ-013 FunSel decode SHALL be:
- 0000 A; 0001 B; 0010 ~A; 0011 ~B
- 0100 A+B; 0101 A+B+C; 0110 A-B
- 0111 A&B; 1000 A|B; 1001 A^B
- 1010 LSL A; 1011 LSR A; 1100 ASR A; 1101 CSL A (C into bit0, bit15 into C); 1110 CSR A (C into bit15, bit0 into C)
- 1111 MUL: low 16 bits of A*B, unsigned.
REQ-014 The FSM SHALL have the states IDLE, MUL and DONE, with these transitions:
- IDLE -> MUL on Start=1 with FunSel=1111.
- IDLE -> DONE on Start=1 with any other FunSel.
- MUL -> DONE after 16 iterations.
- DONE -> IDLE unconditionally.
REQ-015 At the rising edge where Start=1 in IDLE, the block SHALL latch A, B, FunSel, WF and the current C.
- Single-cycle ops: ALUOut and flags SHALL update at that same edge.
- Done=1 for exactly the following cycle.
REQ-016 MUL SHALL be an iterative shift-add, one bit per clock.
- Busy=1 from the Start edge until the 16th iteration edge.
- ALUOut updates at the 16th iteration edge, and Done=1 in the cycle after it.
- Total: Done is high in cycle 17 after Start.
REQ-017 Busy SHALL be 0 in IDLE and DONE; Done SHALL be 1 only in DONE.
REQ-018 Start SHALL be ignored while Busy=1 or Done=1; there is no queuing.
REQ-019 Flags SHALL update only when the latched WF=1; otherwise all four flags hold.
REQ-020 Z = (result==0) and N = result[15] for every op.
REQ-021 C rules:
- add: carry out of bit 15.
- sub: 1 when A<B unsigned (borrow).
- shifts: the bit shifted out.
- MUL: 1 when the high 16 bits of the product are nonzero.
- logic/move ops: C holds.
REQ-022 O rules:
- add: signed overflow.
- sub: signed overflow.
- ASR: 0.
- all other ops: O holds.
REQ-023 Arithmetic SHALL be modulo 2^16 with no saturation; A+B+C uses the latched C.
REQ-024 Operand changes on A/B/FunSel after the Start edge SHALL NOT affect an in-progress MUL.

Reset
REQ-025 Reset=1 SHALL immediately force the following, regardless of Clock:
- ALUOut=0000h, FlagsOut=0000, Busy=0, Done=0.
- FSM to IDLE and the latched operands cleared.
REQ-026 Reset asserted mid-MUL SHALL abort the operation with no Done pulse; after release the block SHALL accept Start on the first rising edge.

Verification
REQ-027 A=7FFFh, B=0001h, FunSel=0100, WF=1, Start -> next cycle ALUOut=8000h, Done=1, flags Z=0,C=0,N=1,O=1.
REQ-028 A=0003h, B=0005h, FunSel=0110, WF=1 -> ALUOut=FFFEh, C=1, N=1, O=0; repeat with WF=0 and A=B -> ALUOut=0000h, flags unchanged.
REQ-029 A=0100h, B=0100h, FunSel=1111, WF=1 -> Busy high for 16 cycles, Done in cycle 17, ALUOut=0000h, Z=1, C=1; Start pulses during Busy are ignored.
REQ-030 C=1, A=8001h, FunSel=1101 -> ALUOut=0003h, C=1; then FunSel=1110 on A=0002h with C=1 -> ALUOut=8001h, C=0.
REQ-031 Start MUL, assert Reset at cycle 8 -> all outputs 0 at once, no Done; after release, FunSel=0000 with A=1234h -> ALUOut=1234h, Done in the next cycle.
